// File: rtl/adder_pkg.sv
// Shared types and constants for the sequential 2-bit-slice adder.
// The controller walks the operands one SLICE_W-wide pair per cycle.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE_W = 2;

  // Slice index width; a single-slice operand still needs a 1-bit index.
  function automatic int idx_width(input int width);
    return (width / SLICE_W > 1) ? $clog2(width / SLICE_W) : 1;
  endfunction

endpackage

// File: rtl/adder2_slice.sv
// Combinational 2-bit ripple adder cell with the established
// a0, b0, a1, b1, c0 -> s1, s0, c2 port order.
module adder2_slice (
  input  logic a0,
  input  logic b0,
  input  logic a1,
  input  logic b1,
  input  logic c0,
  output logic s1,
  output logic s0,
  output logic c2
);

  logic w_c1;

  assign s0   = a0 ^ b0 ^ c0;
  assign w_c1 = (a0 & b0) | (a0 & c0) | (b0 & c0);
  assign s1   = a1 ^ b1 ^ w_c1;
  assign c2   = (a1 & b1) | (a1 & w_c1) | (b1 & w_c1);

endmodule

// File: rtl/adder2_seq_ctrl.sv
// WIDTH-bit adder built from one shared 2-bit slice, one pair per cycle,
// LSB pair first, with a registered carry chaining consecutive pairs.
module adder2_seq_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output state_t           o_dbg_state
);

  localparam int HALF  = WIDTH / SLICE_W;
  localparam int IDX_W = idx_width(WIDTH);

  if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
    $error("adder2_seq_ctrl: WIDTH must be even and >= 2");
  end

  // Handshake: start is accepted only in IDLE or DONE; done pulses for one
  // cycle with sum/cout valid, and sum/cout hold until the next accept.
  state_t               r_state;
  state_t               w_next_state;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [WIDTH-1:0]     r_sum;
  logic                 r_cout;
  logic                 r_carry;
  logic [IDX_W-1:0]     r_idx;
  logic [SLICE_W-1:0]   w_a_pair;
  logic [SLICE_W-1:0]   w_b_pair;
  logic                 w_s0;
  logic                 w_s1;
  logic                 w_c2;
  logic                 w_last;
  logic                 w_accept;

  assign w_a_pair = SLICE_W'(r_a >> {r_idx, 1'b0});
  assign w_b_pair = SLICE_W'(r_b >> {r_idx, 1'b0});
  assign w_last   = (r_idx == IDX_W'(HALF - 1));
  assign w_accept = start && (r_state != RUN);

  adder2_slice u_slice (
    .a0 (w_a_pair[0]),
    .b0 (w_b_pair[0]),
    .a1 (w_a_pair[1]),
    .b1 (w_b_pair[1]),
    .c0 (r_carry),
    .s1 (w_s1),
    .s0 (w_s0),
    .c2 (w_c2)
  );

  always_comb begin
    w_next_state = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next_state = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_next_state = DONE;
      end
      DONE: begin
        done         = 1'b1;
        w_next_state = start ? RUN : IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_carry <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_a     <= a;
        r_b     <= b;
        r_carry <= cin;
        r_idx   <= '0;
        r_sum   <= '0;
        r_cout  <= 1'b0;
      end else if (r_state == RUN) begin
        r_sum[{r_idx, 1'b0} +: SLICE_W] <= {w_s1, w_s0};
        r_carry <= w_c2;
        // Index stays on the last pair so it never wraps within an operation.
        if (w_last) begin
          r_cout <= w_c2;
        end else begin
          r_idx <= r_idx + IDX_W'(1);
        end
      end
    end
  end

  assign sum         = r_sum;
  assign cout        = r_cout;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_adder2_seq_ctrl.sv
// Randomized bench for adder2_seq_ctrl against an arithmetic reference
// ({cout,sum} = a + b + cin) with cycle-exact busy/done protocol checks.
module tb_adder2_seq_ctrl;
  import adder_pkg::*;

  localparam int W    = 8;
  localparam int HALF = W / 2;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  state_t       dbg_state;

  logic [W:0] exp_q[$];
  int checks;
  int errors;

  adder2_seq_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .busy        (busy),
    .done        (done),
    .sum         (sum),
    .cout        (cout),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a request at the current negedge; returns at the next negedge
  // (first RUN cycle) with start dropped and inputs scrambled.
  task automatic drive_start(input logic [W-1:0] a_i, input logic [W-1:0] b_i, input logic c_i);
    logic [W:0] ref_sum;
    start = 1'b1;
    a     = a_i;
    b     = b_i;
    cin   = c_i;
    ref_sum = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, c_i};
    exp_q.push_back(ref_sum);
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    cin   = 1'($urandom);
  endtask

  // Busy for HALF cycles; returns at the negedge of the expected done cycle.
  task automatic check_run(input string tag);
    for (int k = 1; k <= HALF; k++) begin
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_nodone"}, 32'(done), 32'd0);
      @(negedge clk);
    end
  endtask

  task automatic check_done(input string tag);
    logic [W:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_result"}, 32'({cout, sum}), 32'(e));
  endtask

  task automatic op(input string tag, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                    input logic c_i);
    drive_start(a_i, b_i, c_i);
    check_run(tag);
    check_done(tag);
    @(negedge clk);
    check({tag, "_pulse_end"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [W:0] held;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'({cout, sum}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // directed cases
    op("basic", 8'h5A, 8'h3C, 1'b0);
    check("hold_result", 32'({cout, sum}), 32'h096);
    op("ripple", 8'hFF, 8'h01, 1'b0);
    op("cin_ripple", 8'hFF, 8'h00, 1'b1);
    op("cin_only", 8'h00, 8'h00, 1'b1);

    // start re-pulsed in the 2nd RUN cycle is ignored
    drive_start(8'h5A, 8'h3C, 1'b0);
    for (int k = 1; k <= HALF; k++) begin
      check("ign_busy", 32'(busy), 32'd1);
      start = (k == 2);
      if (k == 2) begin
        a = 8'h11;
        b = 8'h11;
      end
      @(negedge clk);
      start = 1'b0;
    end
    check_done("ignore");
    @(negedge clk);
    check("ignore_single_done", 32'(done), 32'd0);

    // back-to-back: start held through DONE
    drive_start(8'h5A, 8'h3C, 1'b0);
    check_run("b2b_first");
    check_done("b2b_first");
    drive_start(8'h0F, 8'h01, 1'b0);
    check_run("b2b_second");
    check_done("b2b_second");
    @(negedge clk);

    // asynchronous reset in the 3rd RUN cycle
    drive_start(8'h5A, 8'h3C, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_result", 32'({cout, sum}), 32'd0);
    void'(exp_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < HALF + 1; k++) begin
      check("arst_no_done", 32'(done), 32'd0);
      @(negedge clk);
    end
    op("after_rst", 8'h80, 8'h80, 1'b0);

    // randomized operations, some chained back-to-back
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        drive_start(W'($urandom), W'($urandom), 1'($urandom));
        check_run("rnd_b2b_a");
        check_done("rnd_b2b_a");
        drive_start(W'($urandom), W'($urandom), 1'($urandom));
        check_run("rnd_b2b_b");
        check_done("rnd_b2b_b");
        @(negedge clk);
      end else begin
        op("rnd", W'($urandom), W'($urandom), 1'($urandom));
      end
      held = {cout, sum};
      repeat ($urandom_range(0, 2)) @(negedge clk);
      check("rnd_hold", 32'({cout, sum}), 32'(held));
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
